// File: rtl/alu_arbiter_if.sv
// Request/response channel between the issue units and alu_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/consumer side.
interface alu_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 64
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*4-1:0]     req_ctrl;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_carry;
  logic                  rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU among NREQ requesters, one op in flight.
// Optional opcode screening is compiled in with `define ALU_OPCHK_EN.
module alu_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry
);

  localparam int         IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] OP_ADD = 4'b0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [NREQ-1:0]  ready_c;
  logic             accept;
  logic             capture;
  logic             release_rsp;

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_ctrl;
  logic             op_bad;
  logic             drop_res;

  logic [IDW-1:0]   id_p0;
  logic             vld_p1;
  logic [IDW-1:0]   id_p1;
  logic [WIDTH-1:0] data_p1;
  logic             carry_p1;

  // Index 'step' positions after 'base', wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

`ifdef ALU_OPCHK_EN
  function automatic logic op_legal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction
`endif

  // Highest-priority candidate is the one right after last_grant; the
  // descending scan lets the nearest valid requester overwrite farther ones.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req_valid[rr_next(last_grant, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_next(last_grant, k);
      end
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a    = bus.req_a[i*WIDTH +: WIDTH];
        sel_b    = bus.req_b[i*WIDTH +: WIDTH];
        sel_ctrl = bus.req_ctrl[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ready_c     = '0;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          ready_c[gnt_idx] = 1'b1;
          accept           = 1'b1;
          state_nx         = EXEC;
        end
      end
      EXEC: begin
        capture  = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          release_rsp = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.req_ready = ready_c;

  // Stage p0: grant edge, operands registered into the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      id_p0      <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else if (accept) begin
      alu_a      <= sel_a;
      alu_b      <= sel_b;
      alu_ctrl   <= op_bad ? 4'b0000 : sel_ctrl;
      id_p0      <= gnt_idx;
      last_grant <= gnt_idx;
    end
  end

  // Stage p1: ALU result captured and held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      id_p1    <= '0;
      data_p1  <= '0;
      carry_p1 <= 1'b0;
    end else if (capture) begin
      vld_p1   <= 1'b1;
      id_p1    <= id_p0;
      data_p1  <= drop_res ? '0 : alu_out;
      carry_p1 <= alu_carry & (alu_ctrl == OP_ADD) & ~drop_res;
    end else if (release_rsp) begin
      vld_p1   <= 1'b0;
    end
  end

`ifdef ALU_OPCHK_EN
  logic err_p0;
  logic err_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p0 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      if (accept)  err_p0 <= op_bad;
      if (capture) err_p1 <= err_p0;
    end
  end

  assign op_bad      = ~op_legal(sel_ctrl);
  assign drop_res    = err_p0;
  assign bus.rsp_err = err_p1;
`else
  assign op_bad      = 1'b0;
  assign drop_res    = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_id    = id_p1;
  assign bus.rsp_data  = data_p1;
  assign bus.rsp_carry = carry_p1;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ready_c));
  a_ready_idle:   assert property (@(posedge clk) disable iff (!rst_n) (state != IDLE) |-> (ready_c == '0));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stand-in, scoreboard of expected responses,
// directed scenarios followed by randomized traffic with random back-pressure.
module tb_alu_arbiter;
  localparam int NREQ  = 3;
  localparam int WIDTH = 64;
  localparam int IDW   = 2;

  localparam logic [3:0]  OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010;
  localparam logic [3:0]  OP_SUB = 4'b0110, OP_PASSB = 4'b0111, OP_NOR = 4'b1100;
  localparam logic [63:0] BADOP  = 64'hBAD0_BAD0_BAD0_BAD0;
  localparam logic [63:0] MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;
`ifdef ALU_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [3:0]       alu_ctrl;
  logic             alu_carry;
  logic             force_carry = 1'b0;

  alu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_out   (alu_out),
    .alu_carry (alu_carry)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] alu_fn(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    case (c)
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_PASSB: return b;
      OP_NOR:   return ~(a | b);
      default:  return BADOP;
    endcase
  endfunction

  function automatic logic add_ovf(input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] s;
    s = $signed({a[63], a}) + $signed({b[63], b});
    return s[64] ^ s[63];
  endfunction

  function automatic bit legal(input logic [3:0] c);
    return c inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_NOR};
  endfunction

  // Stand-in ALU: carry output is raw overflow (or forced), independent of opcode.
  always_comb begin
    alu_out   = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_carry = force_carry | add_ovf(alu_a, alu_b);
  end

  typedef struct {
    int          id;
    logic [63:0] a, b, data;
    logic [3:0]  ctrl;
    logic        carry, err;
  } exp_t;

  exp_t sb[$];
  int   model_last = NREQ - 1;
  bit   busy = 0, exec_pend = 0, rsp_pend = 0;
  int   grant_cnt[NREQ];

  initial for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;

  always @(negedge clk) begin
    exp_t            e;
    int              w;
    bit              done;
    logic [NREQ-1:0] exr;
    logic [3:0]      c;
    if (!rst_n) begin
      sb.delete();
      model_last = NREQ - 1;
      busy = 0; exec_pend = 0; rsp_pend = 0;
    end else begin
      done = 0;
      if (exec_pend) begin
        exec_pend = 0;
        rsp_pend  = 1;
        if (sb.size() > 0) begin
          e = sb[$];
          chk("exec_a", alu_a, e.a);
          chk("exec_b", alu_b, e.b);
          chk("exec_ctrl", {60'd0, alu_ctrl}, {60'd0, e.ctrl});
        end
        chk("exec_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
      end else if (rsp_pend) begin
        rsp_pend = 0;
        chk("rsp_latency", {63'd0, bus.rsp_valid}, 64'd1);
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", 64'd1, 64'd0);
        end else begin
          chk("rsp_id", {62'd0, bus.rsp_id}, 64'(sb[0].id));
          chk("rsp_data", bus.rsp_data, sb[0].data);
          chk("rsp_carry", {63'd0, bus.rsp_carry}, {63'd0, sb[0].carry});
          chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, sb[0].err});
        end
        if (bus.rsp_ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          done = 1;
        end
      end
      if (busy) begin
        chk("ready_busy", {61'd0, bus.req_ready}, 64'd0);
      end else begin
        w = -1;
        for (int k = NREQ; k >= 1; k--)
          if (bus.req_valid[(model_last + k) % NREQ]) w = (model_last + k) % NREQ;
        if (w < 0) begin
          chk("ready_idle", {61'd0, bus.req_ready}, 64'd0);
        end else begin
          exr    = '0;
          exr[w] = 1'b1;
          chk("grant", {61'd0, bus.req_ready}, {61'd0, exr});
          c       = bus.req_ctrl[w*4 +: 4];
          e.id    = w;
          e.a     = bus.req_a[w*WIDTH +: WIDTH];
          e.b     = bus.req_b[w*WIDTH +: WIDTH];
          e.err   = OPCHK && !legal(c);
          e.ctrl  = e.err ? 4'b0000 : c;
          e.data  = e.err ? 64'd0 : alu_fn(c, e.a, e.b);
          e.carry = !e.err && (c == OP_ADD) && (force_carry || add_ovf(e.a, e.b));
          sb.push_back(e);
          model_last = w;
          grant_cnt[w]++;
          busy = 1; exec_pend = 1;
        end
      end
      if (done) busy = 0;
    end
  end

  task automatic issue(input int i, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    bit ok;
    @(posedge clk); #1;
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_ctrl[i*4 +: 4]      = c;
    bus.req_valid[i]            = 1'b1;
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (bus.req_ready[i]) ok = 1;
    end
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
    if (!ok) chk("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(posedge clk); #1;
      if (!busy && !bus.rsp_valid) ok = 1;
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int          g0, g1;
    logic [63:0] ra, rb;
    logic [3:0]  op_tab [8];
    op_tab = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_NOR, 4'b0011, 4'b1111};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_ctrl  = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_req_ready", {61'd0, bus.req_ready}, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
    rst_n = 1'b1;

    // Signed-overflow ADD from requester 0
    issue(0, OP_ADD, MAXPOS, 64'd1);
    chk("t1_exec_valid", {63'd0, bus.rsp_valid}, 64'd0);
    @(posedge clk); #1;
    chk("t1_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("t1_rsp_data", bus.rsp_data, 64'h8000_0000_0000_0000);
    chk("t1_rsp_carry", {63'd0, bus.rsp_carry}, 64'd1);
    chk("t1_rsp_id", {62'd0, bus.rsp_id}, 64'd0);
    wait_idle();

    // Two requesters held valid: must alternate
    g0 = grant_cnt[0]; g1 = grant_cnt[1];
    @(posedge clk); #1;
    bus.req_a[0*WIDTH +: WIDTH] = 64'd10;   bus.req_b[0*WIDTH +: WIDTH] = 64'd3;
    bus.req_ctrl[0 +: 4]        = OP_SUB;
    bus.req_a[1*WIDTH +: WIDTH] = 64'hF0;   bus.req_b[1*WIDTH +: WIDTH] = 64'h3C;
    bus.req_ctrl[4 +: 4]        = OP_AND;
    bus.req_valid[1:0]          = 2'b11;
    repeat (24) @(posedge clk);
    #1;
    bus.req_valid = '0;
    wait_idle();
    chk("t2_req0_served", 64'(grant_cnt[0] - g0 >= 3), 64'd1);
    chk("t2_req1_served", 64'(grant_cnt[1] - g1 >= 3), 64'd1);

    // Back-pressure on an OR response while another requester waits
    bus.rsp_ready = 1'b0;
    ra = rnd64(); rb = rnd64();
    issue(1, OP_OR, ra, rb);
    bus.req_valid[0] = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 5; t++) begin
      chk("t3_hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("t3_hold_data", bus.rsp_data, ra | rb);
      chk("t3_ready_zero", {61'd0, bus.req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready    = 1'b1;
    bus.req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("t3_done", {63'd0, bus.rsp_valid}, 64'd0);
    wait_idle();

    // PASS-B with the ALU carry forced high
    force_carry = 1'b1;
    ra = rnd64(); rb = rnd64();
    issue(1, OP_PASSB, ra, rb);
    @(posedge clk); #1;
    chk("t4_carry", {63'd0, bus.rsp_carry}, 64'd0);
    chk("t4_data", bus.rsp_data, rb);
    wait_idle();
    force_carry = 1'b0;

    // Illegal opcode 4'b1111
    ra = rnd64(); rb = rnd64();
    issue(2, 4'b1111, ra, rb);
    chk("t6_alu_ctrl", {60'd0, alu_ctrl}, OPCHK ? 64'd0 : 64'hF);
    @(posedge clk); #1;
    chk("t6_err", {63'd0, bus.rsp_err}, {63'd0, OPCHK});
    chk("t6_data", bus.rsp_data, OPCHK ? 64'd0 : BADOP);
    wait_idle();

    // Reset during EXEC
    issue(0, OP_ADD, 64'h1234_5678_9ABC_DEF0, 64'h1111);
    rst_n = 1'b0;
    #1;
    chk("t5_alu_a", alu_a, 64'd0);
    chk("t5_alu_b", alu_b, 64'd0);
    chk("t5_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
    chk("t5_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("t5_rsp_data", bus.rsp_data, 64'd0);
    chk("t5_rsp_id", {62'd0, bus.rsp_id}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      chk("t5_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    end
    bus.req_valid[1:0] = 2'b11;
    @(negedge clk);
    chk("t5_first_gnt", {61'd0, bus.req_ready}, 64'b001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();

    // Randomized traffic with random back-pressure and drop-outs
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        ra = ($urandom_range(0, 7) == 0) ? MAXPOS : rnd64();
        rb = ($urandom_range(0, 7) == 0) ? 64'd1  : rnd64();
        bus.req_valid[i]            = ($urandom_range(0, 99) < 45);
        bus.req_a[i*WIDTH +: WIDTH] = ra;
        bus.req_b[i*WIDTH +: WIDTH] = rb;
        bus.req_ctrl[i*4 +: 4]      = op_tab[$urandom_range(0, 7)];
      end
      bus.rsp_ready = ($urandom_range(0, 99) < 70);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_idle();
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
